md5_search_scheduler: RTL and testbench

- Sequences an exhaustive decimal-password search across NUM_CORES external pipelined MD5 cores.
- Partitions the ASCII digit space, issues one candidate per core per cycle, and tracks in-flight results with a valid delay line.
- Compares each returned hash to the target and reports the first match.
- Sits between the top-level button/LCD FSM (start, result, status) and the md5 core array.

---
 rtl/md5_sched_pkg.sv | 40 ++++
 rtl/ascii_bcd_counter.sv | 48 ++++
 rtl/md5_search_scheduler.sv | 170 +++++++++++++++++
 tb/tb_md5_search_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/md5_sched_pkg.sv
// Shared types, constants and helpers for the MD5 password-search scheduler.
package md5_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NINE = 8'h39;

   localparam int CAND_W = 64;
   localparam int HASH_W = 128;
   localparam int CHARS  = 8;

   localparam logic [CAND_W-1:0] CAND_ZERO = {CHARS{ASCII_ZERO}};

   // First candidate of core k: leading active digit set to k*10/n, rest '0'.
   function automatic logic [CAND_W-1:0] range_start(input int k, input int n, input int digits);
      logic [CAND_W-1:0] v;
      v = CAND_ZERO;
      v[(digits-1)*8 +: 8] = ASCII_ZERO + 8'((k * 10) / n);
      return v;
   endfunction

   // Keeps the low active digits and holds every unused high character at '0'.
   function automatic logic [CAND_W-1:0] pad_candidate(input logic [CAND_W-1:0] low, input int digits);
      logic [CAND_W-1:0] v;
      v = CAND_ZERO;
      for (int i = 0; i < CHARS; i++) begin
         if (i < digits) begin
            v[i*8 +: 8] = low[i*8 +: 8];
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/ascii_bcd_counter.sv
// Decimal counter kept directly in ASCII, one character per digit, LSB = rightmost digit.
// wrap is high while every digit is '9', i.e. the next increment rolls over to all '0'.
module ascii_bcd_counter
   import md5_sched_pkg::*;
#(
   parameter int NDIG = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [NDIG*8-1:0] load_value,
   input  logic              inc,
   output logic [NDIG*8-1:0] value,
   output logic              wrap
);

   logic [NDIG*8-1:0] next_value;
   logic              carry;

   // Ripple increment: each '9' becomes '0' and passes the carry up one digit.
   always_comb begin
      next_value = value;
      carry      = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (carry) begin
            if (value[i*8 +: 8] == ASCII_NINE) begin
               next_value[i*8 +: 8] = ASCII_ZERO;
            end else begin
               next_value[i*8 +: 8] = value[i*8 +: 8] + 8'd1;
               carry                = 1'b0;
            end
         end
      end
      wrap = carry;
   end

   // Counter register; load wins over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= {NDIG{ASCII_ZERO}};
      end else if (load) begin
         value <= load_value;
      end else if (inc) begin
         value <= next_value;
      end
   end

endmodule

// File: rtl/md5_search_scheduler.sv
// Drives NUM_CORES pipelined MD5 cores through an exhaustive decimal password search
// and reports the first candidate whose hash equals the target.
// Optional build macro MD5_SCHED_TIMER_EN adds the elapsed_bcd cycle counter output.
module md5_search_scheduler
   import md5_sched_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int PIPE_LAT  = 64,
   parameter int DIGITS    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   input  logic [HASH_W-1:0]           target_hash,
   output logic                        busy,
   output logic                        done,
   output logic                        found,
   output logic [CAND_W-1:0]           result_pwd,
   output logic [NUM_CORES*CAND_W-1:0] core_att,
   input  logic [NUM_CORES*HASH_W-1:0] core_hash,
   input  logic [NUM_CORES*CAND_W-1:0] core_echo
`ifdef MD5_SCHED_TIMER_EN
   ,
   output logic [95:0]                 elapsed_bcd
`endif
);

   localparam int DW = $clog2(PIPE_LAT + 1);

   state_t              state, next_state;
   logic                load_cnt, inc_cnt, take_hit;
   logic                last_issue, line_out, hit;
   logic [NUM_CORES-1:0] wrap_vec;
   logic [CAND_W-1:0]   hit_pwd;
   logic [HASH_W-1:0]   target_q;
   logic [PIPE_LAT-1:0] vline;
   logic [DW-1:0]       drain_cnt;
   logic                drain_last;

   // Only the highest core's range ends on all '9's, so any wrap flag marks the final issue cycle.
   assign last_issue = |wrap_vec;
   assign line_out   = vline[PIPE_LAT-1];
   assign drain_last = (drain_cnt == DW'(PIPE_LAT - 1));
   assign busy       = (state == RUN) || (state == DRAIN);
   assign done       = (state == DONE);

   for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
      localparam logic [CAND_W-1:0] START_K = range_start(k, NUM_CORES, DIGITS);
      logic [DIGITS*8-1:0] cnt_val;

      ascii_bcd_counter #(.NDIG(DIGITS)) u_cnt (
         .clk        (clk),
         .reset      (reset),
         .load       (load_cnt),
         .load_value (START_K[DIGITS*8-1:0]),
         .inc        (inc_cnt),
         .value      (cnt_val),
         .wrap       (wrap_vec[k])
      );

      assign core_att[k*CAND_W +: CAND_W] = pad_candidate(CAND_W'(cnt_val), DIGITS);
   end

   // Compare every returned hash against the target; descending scan so the lowest core wins.
   always_comb begin
      hit     = 1'b0;
      hit_pwd = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (line_out && (core_hash[k*HASH_W +: HASH_W] == target_q)) begin
            hit     = 1'b1;
            hit_pwd = core_echo[k*CAND_W +: CAND_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode; abort overrides everything, including start.
   always_comb begin
      next_state = state;
      load_cnt   = 1'b0;
      inc_cnt    = 1'b0;
      take_hit   = 1'b0;
      if (abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  next_state = RUN;
                  load_cnt   = 1'b1;
               end
            end
            RUN: begin
               if (hit) begin
                  next_state = DONE;
                  take_hit   = 1'b1;
               end else if (last_issue) begin
                  next_state = DRAIN;
               end else begin
                  inc_cnt = 1'b1;
               end
            end
            DRAIN: begin
               if (hit) begin
                  next_state = DONE;
                  take_hit   = 1'b1;
               end else if (drain_last) begin
                  next_state = DONE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Target latch, in-flight valid line, drain timer and the captured result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         target_q   <= '0;
         vline      <= '0;
         drain_cnt  <= '0;
         found      <= 1'b0;
         result_pwd <= '0;
      end else if (load_cnt) begin
         target_q   <= target_hash;
         vline      <= '0;
         drain_cnt  <= '0;
         found      <= 1'b0;
         result_pwd <= '0;
      end else begin
         vline[0] <= (state == RUN);
         for (int i = 1; i < PIPE_LAT; i++) begin
            vline[i] <= vline[i-1];
         end
         if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
         end else begin
            drain_cnt <= '0;
         end
         if (take_hit) begin
            found      <= 1'b1;
            result_pwd <= hit_pwd;
         end
      end
   end

`ifdef MD5_SCHED_TIMER_EN
   logic timer_wrap;

   ascii_bcd_counter #(.NDIG(12)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (load_cnt),
      .load_value ({12{ASCII_ZERO}}),
      .inc        (busy),
      .value      (elapsed_bcd),
      .wrap       (timer_wrap)
   );
`endif

endmodule

// File: tb/tb_md5_search_scheduler.sv
// Scoreboard bench for md5_search_scheduler with a stub core array (hash = {64'h0, att}, echo = att).
module tb_md5_search_scheduler;

   localparam int N  = 2;
   localparam int PL = 4;
   localparam int DG = 3;

   logic           clk = 1'b0;
   logic           reset, start, abort, alias_en;
   logic [127:0]   target_hash;
   logic           busy, done, found;
   logic [63:0]    result_pwd;
   logic [N*64-1:0]  core_att;
   logic [N*128-1:0] core_hash;
   logic [N*64-1:0]  core_echo;
`ifdef MD5_SCHED_TIMER_EN
   logic [95:0]    elapsed_bcd;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int start_cycle = 0;
   logic done_prev = 1'b0;

   typedef struct {
      int          id;
      logic        found;
      logic [63:0] pwd;
      int          lat;
   } exp_t;

   exp_t sb[$];

   md5_search_scheduler #(.NUM_CORES(N), .PIPE_LAT(PL), .DIGITS(DG)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .target_hash (target_hash),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .result_pwd  (result_pwd),
      .core_att    (core_att),
      .core_hash   (core_hash),
      .core_echo   (core_echo)
`ifdef MD5_SCHED_TIMER_EN
      ,
      .elapsed_bcd (elapsed_bcd)
`endif
   );

   always #5 clk = ~clk;

   // Cycle counter used to measure start-to-done latency.
   always @(posedge clk) cyc <= cyc + 1;

   // Stub MD5 cores: fixed PL-cycle delay; alias_en makes core 1 return core 0's hash.
   logic [63:0] pipe0 [PL];
   logic [63:0] pipe1 [PL];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PL; i++) begin
            pipe0[i] <= '0;
            pipe1[i] <= '0;
         end
      end else begin
         pipe0[0] <= core_att[63:0];
         pipe1[0] <= core_att[127:64];
         for (int i = 1; i < PL; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
         end
      end
   end

   assign core_echo = {pipe1[PL-1], pipe0[PL-1]};
   assign core_hash = {64'h0, (alias_en ? pipe0[PL-1] : pipe1[PL-1]), 64'h0, pipe0[PL-1]};

   function automatic logic [95:0] to_ascii12(input int v);
      logic [95:0] r;
      int x;
      x = v;
      for (int i = 0; i < 12; i++) begin
         r[i*8 +: 8] = 8'h30 + 8'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Issues a start pulse; optionally records the expected outcome in the scoreboard.
   task automatic applyStimulus(input int id, input logic [63:0] tgt, input logic ef,
                                input logic [63:0] ep, input int el, input bit push);
      exp_t e;
      @(negedge clk);
      target_hash = {64'h0, tgt};
      start       = 1'b1;
      start_cycle = cyc;
      if (push) begin
         e.id = id; e.found = ef; e.pwd = ep; e.lat = el;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // start pulse that must be ignored (search already running).
   task automatic ignoredStart(input logic [63:0] tgt);
      @(negedge clk);
      target_hash = {64'h0, tgt};
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL timeout_done actual=pending required=done_within_%0d", budget);
         sb.delete();
      end
   endtask

   // Monitor: on each rising done, pop the oldest expectation and compare.
   always @(negedge clk) begin
      exp_t e;
      int lat;
      if (done && !done_prev) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done actual=1 required=0 result=%h", result_pwd);
         end else begin
            e   = sb.pop_front();
            lat = cyc - start_cycle - 1;
            checkOutput($sformatf("T%0d_found", e.id), {127'h0, found}, {127'h0, e.found});
            checkOutput($sformatf("T%0d_result", e.id), {64'h0, result_pwd}, {64'h0, e.pwd});
            checkOutput($sformatf("T%0d_latency", e.id), 128'(lat), 128'(e.lat));
`ifdef MD5_SCHED_TIMER_EN
            checkOutput($sformatf("T%0d_elapsed", e.id), {32'h0, elapsed_bcd}, {32'h0, to_ascii12(e.lat)});
`endif
         end
      end
      done_prev <= done;
   end

   initial begin
      logic [127:0] zeros2;
      zeros2      = {16{8'h30}};
      reset       = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      alias_en    = 1'b0;
      target_hash = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_busy",   {127'h0, busy},  128'h0);
      checkOutput("rst_done",   {127'h0, done},  128'h0);
      checkOutput("rst_found",  {127'h0, found}, 128'h0);
      checkOutput("rst_result", {64'h0, result_pwd}, 128'h0);
      checkOutput("rst_att",    core_att, zeros2);

      // T1: core 0 range, offset 123 -> done PL+1 cycles after issue.
      applyStimulus(1, "00000123", 1'b1, "00000123", 123 + PL + 1, 1'b1);
      waitDone(800);
      repeat (3) @(negedge clk);
      checkOutput("T1_done_hold",   {127'h0, done}, 128'h1);
      checkOutput("T1_result_hold", {64'h0, result_pwd}, {64'h0, 64'("00000123")});

      // T2: core 1 range starts at "500", so "617" is issued at offset 117.
      applyStimulus(2, "00000617", 1'b1, "00000617", 117 + PL + 1, 1'b1);
      waitDone(800);

      // T3: unmatchable; 500 issue cycles plus PL drain; a mid-run start is ignored.
      applyStimulus(3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 500 + PL, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("T3_busy_run", {127'h0, busy}, 128'h1);
      ignoredStart("00000300");
      waitDone(900);

      // T4: core 1 aliased to core 0's hash; both hit together, core 0 echo wins.
      alias_en = 1'b1;
      applyStimulus(4, "00000005", 1'b1, "00000005", 5 + PL + 1, 1'b1);
      waitDone(200);
      alias_en = 1'b0;

      // T5: abort mid-run, then restart; the old in-flight "002" must not hit early.
      applyStimulus(5, "00000002", 1'b1, "00000002", 0, 1'b0);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("T5_busy_abort", {127'h0, busy}, 128'h0);
      checkOutput("T5_done_abort", {127'h0, done}, 128'h0);
      applyStimulus(5, "00000002", 1'b1, "00000002", 2 + PL + 1, 1'b1);
      waitDone(200);

      // T6: "009" issued at offset 9 -> elapsed 14 when timer is built in.
      applyStimulus(6, "00000009", 1'b1, "00000009", 9 + PL + 1, 1'b1);
      waitDone(200);

      // T7: asynchronous reset mid-run discards everything.
      applyStimulus(7, "00000123", 1'b1, "00000123", 0, 1'b0);
      repeat (20) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("T7_busy_reset", {127'h0, busy}, 128'h0);
      checkOutput("T7_att_reset",  core_att, zeros2);
      @(negedge clk);
      reset = 1'b0;
      repeat (200) @(negedge clk);
      checkOutput("T7_no_done", {127'h0, done}, 128'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
